// File: rtl/input_conditioner_pkg.sv
// Shared constants for the CPU digital-input path: DINP width, the number of
// hardware-settable FLAG bits and the default debounce length.
package input_conditioner_pkg;

  localparam int DINP_WIDTH              = 8;
  localparam int FLAG_HW_BITS            = 7;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // FLAG bits at or above FLAG_HW_BITS belong to software and are never pulsed.
  localparam logic [DINP_WIDTH-1:0] FLAG_HW_MASK =
    DINP_WIDTH'((1 << FLAG_HW_BITS) - 1);

  typedef logic [DINP_WIDTH-1:0] dinp_t;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a debounce counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  output logic level
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync;
  logic [CW-1:0] count;
  logic          stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  // Any sample matching the accepted level restarts qualification from zero,
  // so a reversal mid-count never leaks through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      stable <= 1'b0;
    end else if (enable) begin
      if (sync == stable) begin
        count <= '0;
      end else if (count == LAST) begin
        stable <= sync;
        count  <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises, debounces and edge-detects the external 8-bit input, feeding
// DINP write data and one-cycle FLAG set-pulses to the register file.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int                    DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [DINP_WIDTH-1:0] RISE_MASK       = 8'h7F,
  parameter logic [DINP_WIDTH-1:0] FALL_MASK       = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DINP_WIDTH-1:0] din_raw,
  input  logic                  enable,
  output logic [DINP_WIDTH-1:0] reg_din,
  output logic [DINP_WIDTH-1:0] flag_inputs,
  output logic                  change
);

  dinp_t stable;
  dinp_t stable_d;
  dinp_t rise;
  dinp_t fall;
  dinp_t flag_next;

  for (genvar i = 0; i < DINP_WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .enable(enable),
      .raw   (din_raw[i]),
      .level (stable[i])
    );
  end

  // stable_d follows stable even while disabled, so re-enabling cannot
  // replay an edge that happened before the freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  always_comb begin
    rise      = stable & ~stable_d;
    fall      = ~stable & stable_d;
    flag_next = ((rise & RISE_MASK) | (fall & FALL_MASK)) & FLAG_HW_MASK;
    if (!enable) begin
      flag_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_inputs <= '0;
    end else begin
      flag_inputs <= flag_next;
    end
  end

  assign reg_din = stable;
  assign change  = |flag_inputs;

endmodule
